// File: rtl/mult_window_seq.sv
// Iterative product of the last DEPTH non-ignored samples, one factor per clock.
// Define IGN_CNT_EN to add ign_cnt_o, a saturating count of dropped samples.
module mult_window_seq #(
    parameter int unsigned  W     = 4,
    parameter int unsigned  DEPTH = 2,
    parameter logic [W-1:0] IGN   = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [W-1:0]         in_data_i,
    input  logic                 ld_i,
    output logic                 out_valid_o,
    output logic [W*DEPTH-1:0]   out_data_o,
`ifdef IGN_CNT_EN
    output logic [7:0]           ign_cnt_o,
`endif
    output logic                 busy_o
);

    localparam int unsigned     PW      = W * DEPTH;
    localparam int unsigned     CntW    = $clog2(DEPTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e            state_q;
    logic [PW-1:0]     hist_q;
    logic [PW-1:0]     work_q;
    logic [W-1:0]      ign_q;
    logic [PW-1:0]     acc_q;
    logic [CntW-1:0]   cnt_q;
    logic [PW-1:0]     out_data_q;
    logic              out_valid_q;

    logic              accept;
    logic              drop;
    logic [PW-1:0]     hist_d;
    logic [PW-1:0]     prod;

    assign accept = in_valid_i && (state_q == StIdle) && !ld_i;
    assign drop   = accept && (in_data_i == ign_q);
    // Newest sample lives in the low W bits; the oldest falls off the top.
    assign hist_d = {hist_q[PW-W-1:0], in_data_i};
    assign prod   = acc_q * PW'(work_q[cnt_q*W +: W]);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            work_q      <= '0;
            ign_q       <= IGN;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (ld_i) begin
                ign_q <= in_data_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept && !drop) begin
                        hist_q  <= hist_d;
                        work_q  <= hist_d;
                        acc_q   <= PW'(in_data_i);
                        cnt_q   <= CntW'(1);
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_q <= prod;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        out_data_q  <= prod;
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IGN_CNT_EN
    logic [7:0] ign_cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ign_cnt_q <= '0;
        end else if (ld_i) begin
            ign_cnt_q <= '0;
        end else if (drop && (ign_cnt_q != 8'hFF)) begin
            ign_cnt_q <= ign_cnt_q + 8'd1;
        end
    end

    assign ign_cnt_o = ign_cnt_q;
`endif

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q == StMul);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_mult_window_seq.sv
// Bench for mult_window_seq: two configurations (W4/D2, W6/D3) against a window-product model.
module tb_mult_window_seq;

    localparam int unsigned   WA   = 4;
    localparam int unsigned   DA   = 2;
    localparam int unsigned   WB   = 6;
    localparam int unsigned   DB   = 3;
    localparam logic [WA-1:0] IGNA = 4'd0;
    localparam logic [WB-1:0] IGNB = 6'd7;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  vld;
    logic [1:0]  ldv;
    logic [7:0]  din [2];

    logic        rdy_a, ov_a, busy_a;
    logic [7:0]  od_a;
    logic        rdy_b, ov_b, busy_b;
    logic [17:0] od_b;
`ifdef IGN_CNT_EN
    logic [7:0]  ic_a, ic_b;
`endif

    mult_window_seq #(.W(WA), .DEPTH(DA), .IGN(IGNA)) dut_a (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid_i (vld[0]),
        .in_ready_o (rdy_a),
        .in_data_i  (din[0][3:0]),
        .ld_i       (ldv[0]),
        .out_valid_o(ov_a),
        .out_data_o (od_a),
`ifdef IGN_CNT_EN
        .ign_cnt_o  (ic_a),
`endif
        .busy_o     (busy_a)
    );

    mult_window_seq #(.W(WB), .DEPTH(DB), .IGN(IGNB)) dut_b (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid_i (vld[1]),
        .in_ready_o (rdy_b),
        .in_data_i  (din[1][5:0]),
        .ld_i       (ldv[1]),
        .out_valid_o(ov_b),
        .out_data_o (od_b),
`ifdef IGN_CNT_EN
        .ign_cnt_o  (ic_b),
`endif
        .busy_o     (busy_b)
    );

    int n_vec;
    int n_err;

    // Model: accepted-sample history (newest first), countdown to the pending pulse.
    int              dep [2] = '{2, 3};
    logic [7:0]      msk [2] = '{8'h0F, 8'h3F};
    longint unsigned mh [2][8];
    longint unsigned mign [2];
    longint unsigned mpend [2];
    longint unsigned mdat [2];
    int              mleft [2];
    int              mic [2];
    bit              mval [2];
    bit              macc [2];
    longint unsigned plog0 [$];
    longint unsigned plog1 [$];

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mh[d][i] = 0;
            mpend[d] = 0;
            mdat[d]  = 0;
            mleft[d] = 0;
            mic[d]   = 0;
            mval[d]  = 0;
            macc[d]  = 0;
        end
        mign[0] = IGNA;
        mign[1] = IGNB;
    endtask

    task automatic predict(input int d);
        longint unsigned p;
        mval[d] = 0;
        macc[d] = 0;
        if (mleft[d] > 0) begin
            mleft[d]--;
            if (mleft[d] == 0) begin
                mval[d] = 1;
                mdat[d] = mpend[d];
            end
        end else if (vld[d] && !ldv[d]) begin
            macc[d] = 1;
            if (din[d] == mign[d]) begin
                if (mic[d] < 255) mic[d]++;
            end else begin
                for (int i = 7; i > 0; i--) mh[d][i] = mh[d][i-1];
                mh[d][0] = din[d];
                p = 1;
                for (int i = 0; i < dep[d]; i++) p = p * mh[d][i];
                mpend[d] = p;
                mleft[d] = dep[d] - 1;
            end
        end
        if (ldv[d]) begin
            mign[d] = din[d];
            mic[d]  = 0;
        end
    endtask

    task automatic model_step();
        longint unsigned a_od [2];
        bit a_ov [2];
        bit a_rdy [2];
        bit a_bsy [2];
        a_ov[0] = ov_a;   a_ov[1] = ov_b;
        a_od[0] = od_a;   a_od[1] = od_b;
        a_rdy[0] = rdy_a; a_rdy[1] = rdy_b;
        a_bsy[0] = busy_a; a_bsy[1] = busy_b;
        if (ov_a) plog0.push_back(od_a);
        if (ov_b) plog1.push_back(od_b);
        if (!rst_b) model_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d out_valid", d), a_ov[d], mval[d]);
            check($sformatf("dut%0d out_data", d), a_od[d], mdat[d]);
            check($sformatf("dut%0d in_ready", d), a_rdy[d], mleft[d] == 0);
            check($sformatf("dut%0d busy", d), a_bsy[d], mleft[d] != 0);
        end
`ifdef IGN_CNT_EN
        check("dut0 ign_cnt", ic_a, mic[0]);
        check("dut1 ign_cnt", ic_b, mic[1]);
`endif
        if (rst_b) begin
            predict(0);
            predict(1);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the model looks on the falling edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int d, input int unsigned v);
        bit done;
        done   = 0;
        vld[d] = 1'b1;
        ldv[d] = 1'b0;
        din[d] = 8'(v) & msk[d];
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            done = macc[d];
        end
        vld[d] = 1'b0;
        check($sformatf("dut%0d accepted within bound", d), done, 1);
    endtask

    task automatic load(input int d, input int unsigned v);
        ldv[d] = 1'b1;
        din[d] = 8'(v) & msk[d];
        tick();
        ldv[d] = 1'b0;
    endtask

    // Reset lands between clock edges so its asynchronous effect is visible before any edge.
    task automatic do_reset();
        #2;
        rst_b = 1'b0;
        vld   = '0;
        ldv   = '0;
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    initial begin
        int r;
        int k;
        n_vec  = 0;
        n_err  = 0;
        vld    = '0;
        ldv    = '0;
        din[0] = '0;
        din[1] = '0;
        model_reset();
        tick();
        check("reset out_data", od_a, 0);
        check("reset in_ready", rdy_a, 1);
        rst_b = 1'b1;
        tick();

        send(0, 5);  idle(3);
        send(0, 10); idle(3);
        send(0, 0);  idle(3);
        send(0, 5);  idle(3);
        load(0, 10);
        send(0, 10); idle(2);
        send(0, 3);  idle(3);
        check("dir pulses count", plog0.size(), 4);
        if (plog0.size() == 4) begin
            check("dir 5*0", plog0[0], 0);
            check("dir 10*5", plog0[1], 50);
            check("dir 5*10", plog0[2], 50);
            check("dir 3*5", plog0[3], 15);
        end
`ifdef IGN_CNT_EN
        load(0, 9);
        send(0, 9); send(0, 9); send(0, 9);
        check("ign_cnt three drops", ic_a, 3);
        load(0, 9);
        check("ign_cnt cleared by ld", ic_a, 0);
`endif

        send(1, 63); send(1, 63); send(1, 63); idle(4);
        check("w6d3 pulses count", plog1.size(), 3);
        if (plog1.size() == 3) check("w6d3 63^3", plog1[2], 250047);

        plog0.delete();
        send(0, 7);
        do_reset();
        check("abort out_data", od_a, 0);
        send(0, 0);  idle(3);
        send(0, 4);  idle(3);
        send(0, 4);  idle(3);
        check("post-reset pulses count", plog0.size(), 2);
        if (plog0.size() == 2) begin
            check("post-reset 4*0", plog0[0], 0);
            check("post-reset 4*4", plog0[1], 16);
        end

        for (int c = 0; c < 2000; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (vld[d] && !macc[d]) begin
                    ldv[d] = 1'b0;
                end else begin
                    r      = $urandom_range(0, 15);
                    ldv[d] = (r == 0);
                    vld[d] = (r >= 5);
                    k      = $urandom_range(0, 3);
                    if (k == 0)      din[d] = 8'(mign[d]);
                    else if (k == 1) din[d] = 8'd0;
                    else             din[d] = 8'($urandom) & msk[d];
                end
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end
        vld = '0;
        ldv = '0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
